wb_upsize_bridge: RTL
=====================

WB_UPSIZE_BRIDGE -- requirements
Module: wb_upsize_bridge

Interface
REQ-001 The block SHALL have parameter READ_BUF, default 1, which enables the 32-bit read buffer (0 = every read goes to the hi bus).
REQ-002 The block SHALL have parameter TIMEOUT, default 256, the hi-bus cycle limit before an error response (0 = no limit).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these lo-side (16-bit slave) ports:
- wb_lo_adr_i  in  32  byte address
- wb_lo_dat_i  in  16  write data
- wb_lo_dat_o  out  16  read data
- wb_lo_cyc_i, wb_lo_stb_i, wb_lo_we_i  in  1 each  cycle, strobe, write enable
- wb_lo_sel_i  in  2  byte selects
- wb_lo_ack_o, wb_lo_err_o, wb_lo_rty_o  out  1 each  terminations
REQ-005 The block SHALL have these hi-side (32-bit master) ports:
- wb_hi_adr_o  out  32  word-aligned address
- wb_hi_dat_o  out  32  write data
- wb_hi_dat_i  in  32  read data
- wb_hi_cyc_o, wb_hi_stb_o, wb_hi_we_o  out  1 each  cycle, strobe, write enable
- wb_hi_sel_o  out  4  byte selects
- wb_hi_ack_i, wb_hi_err_i, wb_hi_rty_i  in  1 each  terminations

Function
REQ-006 The block SHALL use the FSM states IDLE, HI_REQ and RESP.
REQ-007 In IDLE, a read with wb_lo_cyc_i&wb_lo_stb_i SHALL hit when READ_BUF=1, buf_valid=1 and buf_tag==wb_lo_adr_i[31:2]; a hit SHALL go to RESP with ack.
REQ-008 Any other request in IDLE SHALL register address, we, sel and data, then go to HI_REQ.
REQ-009 In HI_REQ:
- wb_hi_cyc_o=wb_hi_stb_o=1, wb_hi_adr_o={adr[31:2],2'b00}, wb_hi_we_o=we.
- wb_hi_dat_o={dat,dat}.
- Writes: wb_hi_sel_o = adr[1] ? {sel,2'b00} : {2'b00,sel}.
- Reads: wb_hi_sel_o=4'hF if READ_BUF=1, else the write mapping.
REQ-010 HI_REQ SHALL end on the first of ack_i, err_i or rty_i; if several are asserted together the priority SHALL be err > rty > ack.
REQ-011 On hi read ack, the block SHALL capture wb_hi_dat_i into buf, set buf_tag=adr[31:2] and buf_valid=1 (READ_BUF=1 only).
REQ-012 On a write that reaches HI_REQ, the block SHALL clear buf_valid whenever buf_tag matches, independent of the termination.
REQ-013 If TIMEOUT>0, a counter SHALL count HI_REQ cycles; on reaching TIMEOUT with no termination, the hi cycle SHALL drop and an err response SHALL be given.
REQ-014 RESP SHALL assert exactly one of wb_lo_ack_o, wb_lo_err_o, wb_lo_rty_o for exactly one cycle, then return to IDLE.
REQ-015 Read data SHALL be wb_lo_dat_o = adr[1] ? buf[31:16] : buf[15:0], valid while wb_lo_ack_o=1; otherwise it SHALL be 0.
REQ-016 Latency:
- Hit: request sampled cycle 0, wb_lo_ack_o at cycle 1.
- Miss: wb_hi_stb_o from cycle 1; hi termination at cycle k gives the lo response at cycle k+1.
- The hi cycle drops at cycle k+1.
REQ-017 If wb_lo_cyc_i drops while in HI_REQ, the block SHALL deassert wb_hi_cyc_o/wb_hi_stb_o the next cycle, return to IDLE with no lo response, and leave the buffer unchanged.
REQ-018 A request held across RESP SHALL NOT be re-issued; the block SHALL return to IDLE and accept a new request only after the lo master's stb was low or a new cycle starts (Wishbone classic).

Reset
REQ-019 On wb_rst_i=0, asynchronously:
- state=IDLE.
- All hi and lo outputs = 0.
- buf=0, buf_tag=0, buf_valid=0, timeout counter=0.
REQ-020 Reset assertion mid-HI_REQ SHALL drop wb_hi_cyc_o immediately, with no response issued.

Structure
REQ-021 State encodings and the lane-mapping function SHALL live in a shared defines file, wb_size_bridge_defines, alongside the existing size bridge.
REQ-022 Buffer, tag, valid and hit-compare logic SHALL be one sub-module, wb_upsize_read_buf.

Verification
REQ-023 Read miss at 0x0000_0012 with hi slave returning 0xAABB_CCDD after ack delay 2 -> wb_hi_sel_o=4'hF, wb_hi_adr_o=0x10, wb_lo_dat_o=0xAABB, wb_lo_ack_o one cycle after hi ack.
REQ-024 Then a read at 0x0000_0010 -> no hi cycle, wb_lo_dat_o=0xCCDD at cycle 1.
REQ-025 Write 0x1234 sel=2'b01 at 0x0000_0012 -> wb_hi_sel_o=4'b0100, wb_hi_dat_o=0x1234_1234, buf_valid cleared, next read of 0x10 misses.
REQ-026 Hi slave asserts err (resp. rty) -> lo err (resp. rty) for exactly one cycle, buffer not updated.
REQ-027 Hi slave never responds, TIMEOUT=8 -> wb_hi_cyc_o drops after 8 HI_REQ cycles, wb_lo_err_o=1 for one cycle.
REQ-028 wb_lo_cyc_i dropped during HI_REQ, and wb_rst_i pulsed low mid-HI_REQ -> hi cycle dropped, no lo response, all outputs 0 after reset.

Source files
------------

// File: rtl/wb_size_bridge_defines.sv
// Shared definitions for the Wishbone size bridges: FSM state encodings and
// the 16-bit to 32-bit lane helpers.
package wb_size_bridge_defines;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HI_REQ = 2'd1,
    RESP   = 2'd2
  } upsize_state_e;

  // Place a 16-bit lo-side byte-select pair on the matching half of the 32-bit word.
  function automatic logic [3:0] lane_sel(input logic adr1, input logic [1:0] sel);
    return adr1 ? {sel, 2'b00} : {2'b00, sel};
  endfunction

  // Pick the 16-bit half of a 32-bit word addressed by byte-address bit 1.
  function automatic logic [15:0] lane_dat(input logic adr1, input logic [31:0] word);
    return adr1 ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/wb_upsize_read_buf.sv
// One-entry 32-bit read buffer: data, word tag, valid flag and hit compare.
module wb_upsize_read_buf
  import wb_size_bridge_defines::*;
#(
  parameter int READ_BUF = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [29:0] lookup_tag_i,
  input  logic        fill_en_i,
  input  logic [29:0] fill_tag_i,
  input  logic [31:0] fill_dat_i,
  input  logic        inval_en_i,
  output logic        hit_o,
  output logic [31:0] buf_dat_o
);

  logic [31:0] buf_q, buf_d;
  logic [29:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic        tag_match;

  assign tag_match = (tag_q == lookup_tag_i);
  assign hit_o     = (READ_BUF != 0) && valid_q && tag_match;
  assign buf_dat_o = buf_q;

  // Next state: a fill replaces the entry; a write to the buffered word kills it.
  always_comb begin
    buf_d   = buf_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill_en_i) begin
      buf_d   = fill_dat_i;
      tag_d   = fill_tag_i;
      valid_d = 1'b1;
    end else if (inval_en_i && tag_match) begin
      valid_d = 1'b0;
    end
  end

  // Buffer storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/wb_upsize_bridge.sv
// Wishbone classic bridge from a 16-bit slave port to a 32-bit master port,
// with an optional one-word read buffer and a hi-side cycle timeout.
module wb_upsize_bridge
  import wb_size_bridge_defines::*;
#(
  parameter int READ_BUF = 1,
  parameter int TIMEOUT  = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_lo_adr_i,
  input  logic [15:0] wb_lo_dat_i,
  output logic [15:0] wb_lo_dat_o,
  input  logic        wb_lo_cyc_i,
  input  logic        wb_lo_stb_i,
  input  logic        wb_lo_we_i,
  input  logic [1:0]  wb_lo_sel_i,
  output logic        wb_lo_ack_o,
  output logic        wb_lo_err_o,
  output logic        wb_lo_rty_o,
  output logic [31:0] wb_hi_adr_o,
  output logic [31:0] wb_hi_dat_o,
  input  logic [31:0] wb_hi_dat_i,
  output logic        wb_hi_cyc_o,
  output logic        wb_hi_stb_o,
  output logic        wb_hi_we_o,
  output logic [3:0]  wb_hi_sel_o,
  input  logic        wb_hi_ack_i,
  input  logic        wb_hi_err_i,
  input  logic        wb_hi_rty_i
);

  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
  localparam bit               USE_BUF  = (READ_BUF != 0);
  localparam bit               USE_TMO  = (TIMEOUT > 0);

  upsize_state_e    state_q;
  logic [31:2]      hi_adr_q;
  logic [31:0]      hi_dat_q;
  logic [3:0]       hi_sel_q;
  logic             hi_cyc_q;
  logic             hi_we_q;
  logic             lane_q;
  logic             lo_ack_q, lo_err_q, lo_rty_q;
  logic [15:0]      lo_dat_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             hold_q;

  logic        lo_req, accept, buf_hit, fill_en, inval_en, tmo_hit, hi_done;
  logic [31:0] buf_dat;
  // Byte-address bit 0 has no meaning on a 16-bit port.
  logic        unused_adr0;

  assign unused_adr0 = wb_lo_adr_i[0];
  assign lo_req   = wb_lo_cyc_i & wb_lo_stb_i;
  // hold_q blocks a request still held from the previous response from being re-issued.
  assign accept   = (state_q == IDLE) & lo_req & ~hold_q;
  assign inval_en = accept & wb_lo_we_i;
  assign fill_en  = USE_BUF & (state_q == HI_REQ) & wb_lo_cyc_i & ~hi_we_q
                  & wb_hi_ack_i & ~wb_hi_err_i & ~wb_hi_rty_i;
  assign tmo_hit  = USE_TMO && (tmo_cnt_q == TMO_LAST);
  assign hi_done  = ~wb_lo_cyc_i | wb_hi_err_i | wb_hi_rty_i | wb_hi_ack_i | tmo_hit;

  wb_upsize_read_buf #(.READ_BUF(READ_BUF)) u_read_buf (
    .clk_i        (wb_clk_i),
    .rst_n_i      (wb_rst_i),
    .lookup_tag_i (wb_lo_adr_i[31:2]),
    .fill_en_i    (fill_en),
    .fill_tag_i   (hi_adr_q),
    .fill_dat_i   (wb_hi_dat_i),
    .inval_en_i   (inval_en),
    .hit_o        (buf_hit),
    .buf_dat_o    (buf_dat)
  );

  // Bridge FSM; every output is a register so both buses see glitch-free signals.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= IDLE;
      hi_adr_q  <= '0;
      hi_dat_q  <= '0;
      hi_sel_q  <= '0;
      hi_cyc_q  <= 1'b0;
      hi_we_q   <= 1'b0;
      lane_q    <= 1'b0;
      lo_ack_q  <= 1'b0;
      lo_err_q  <= 1'b0;
      lo_rty_q  <= 1'b0;
      lo_dat_q  <= '0;
      tmo_cnt_q <= '0;
      hold_q    <= 1'b0;
    end else begin
      if (!lo_req) hold_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!wb_lo_we_i && buf_hit) begin
              state_q  <= RESP;
              lo_ack_q <= 1'b1;
              lo_dat_q <= lane_dat(wb_lo_adr_i[1], buf_dat);
              hold_q   <= 1'b1;
            end else begin
              state_q   <= HI_REQ;
              hi_cyc_q  <= 1'b1;
              hi_we_q   <= wb_lo_we_i;
              hi_adr_q  <= wb_lo_adr_i[31:2];
              lane_q    <= wb_lo_adr_i[1];
              hi_dat_q  <= {wb_lo_dat_i, wb_lo_dat_i};
              hi_sel_q  <= (wb_lo_we_i || !USE_BUF) ? lane_sel(wb_lo_adr_i[1], wb_lo_sel_i) : 4'hF;
              tmo_cnt_q <= '0;
            end
          end
        end
        HI_REQ: begin
          if (hi_done) begin
            hi_cyc_q  <= 1'b0;
            hi_we_q   <= 1'b0;
            hi_adr_q  <= '0;
            hi_dat_q  <= '0;
            hi_sel_q  <= '0;
            tmo_cnt_q <= '0;
            state_q   <= wb_lo_cyc_i ? RESP : IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
          // A dropped lo cycle is an abort: no response and no buffer update.
          if (wb_lo_cyc_i && hi_done) begin
            hold_q <= 1'b1;
            if (wb_hi_err_i)      lo_err_q <= 1'b1;
            else if (wb_hi_rty_i) lo_rty_q <= 1'b1;
            else if (wb_hi_ack_i) begin
              lo_ack_q <= 1'b1;
              lo_dat_q <= hi_we_q ? 16'h0000 : lane_dat(lane_q, wb_hi_dat_i);
            end else              lo_err_q <= 1'b1;
          end
        end
        RESP: begin
          lo_ack_q <= 1'b0;
          lo_err_q <= 1'b0;
          lo_rty_q <= 1'b0;
          lo_dat_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_hi_adr_o = {hi_adr_q, 2'b00};
  assign wb_hi_dat_o = hi_dat_q;
  assign wb_hi_sel_o = hi_sel_q;
  assign wb_hi_cyc_o = hi_cyc_q;
  assign wb_hi_stb_o = hi_cyc_q;
  assign wb_hi_we_o  = hi_we_q;
  assign wb_lo_ack_o = lo_ack_q;
  assign wb_lo_err_o = lo_err_q;
  assign wb_lo_rty_o = lo_rty_q;
  assign wb_lo_dat_o = lo_dat_q;

endmodule
